// File: rtl/fwd_unit.sv
// Operand forwarding tracker: two retirement slots (S1 = just left EX, S2 = in WB) muxed over RF read data.
// Define FWD_WB_EN to enable the S2 forwarding path; otherwise S2 hits raise raw_stall instead.
module fwd_unit #(
  parameter int DATAW = 32,
  parameter int REGAW = 4,
  parameter int ALUAW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [ALUAW-1:0] in_opcode,
  input  logic [REGAW-1:0] in_rd,
  input  logic [DATAW-1:0] in_result,
  input  logic [REGAW-1:0] rn,
  input  logic [REGAW-1:0] rm,
  input  logic [DATAW-1:0] rn_rf,
  input  logic [DATAW-1:0] rm_rf,
  output logic [DATAW-1:0] rn_val,
  output logic [DATAW-1:0] rm_val,
  output logic [1:0]       rn_fwd,
  output logic [1:0]       rm_fwd,
  output logic             raw_stall,
  output logic             wb_en,
  output logic [REGAW-1:0] wb_rd,
  output logic [DATAW-1:0] wb_data
);

  localparam logic [REGAW-1:0] PC_REG = {REGAW{1'b1}};
  localparam logic [ALUAW-1:0] OP_TST = ALUAW'(4'h8);
  localparam logic [ALUAW-1:0] OP_TEQ = ALUAW'(4'h9);
  localparam logic [ALUAW-1:0] OP_CMP = ALUAW'(4'hA);
  localparam logic [ALUAW-1:0] OP_CMN = ALUAW'(4'hB);

  logic             s1_valid, s1_wr;
  logic [REGAW-1:0] s1_rd;
  logic [DATAW-1:0] s1_data;
  logic             s2_valid, s2_wr;
  logic [REGAW-1:0] s2_rd;
  logic [DATAW-1:0] s2_data;

  logic in_flag_only;
  logic in_wr;

  assign in_flag_only = (in_opcode == OP_TST) || (in_opcode == OP_TEQ) ||
                        (in_opcode == OP_CMP) || (in_opcode == OP_CMN);
  // R15 results go down the branch path, so they never become forwardable writes.
  assign in_wr = in_valid && !in_flag_only && (in_rd != PC_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_wr    <= 1'b0;
      s1_rd    <= '0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_wr    <= 1'b0;
      s2_rd    <= '0;
      s2_data  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_wr    <= 1'b0;
      s1_rd    <= '0;
      s1_data  <= '0;
      if (!stall) begin
        s2_valid <= s1_valid;
        s2_wr    <= s1_wr;
        s2_rd    <= s1_rd;
        s2_data  <= s1_data;
      end
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_wr    <= in_wr;
      s1_rd    <= in_rd;
      s1_data  <= in_result;
      s2_valid <= s1_valid;
      s2_wr    <= s1_wr;
      s2_rd    <= s1_rd;
      s2_data  <= s1_data;
    end
  end

  logic rn_hit1, rn_hit2, rm_hit1, rm_hit2;
  logic rn_raw, rm_raw;

  assign rn_hit1 = s1_valid && s1_wr && (s1_rd == rn) && (rn != PC_REG);
  assign rn_hit2 = s2_valid && s2_wr && (s2_rd == rn) && (rn != PC_REG);
  assign rm_hit1 = s1_valid && s1_wr && (s1_rd == rm) && (rm != PC_REG);
  assign rm_hit2 = s2_valid && s2_wr && (s2_rd == rm) && (rm != PC_REG);

  always_comb begin
    rn_fwd = 2'd0;
    rn_val = rn_rf;
    rn_raw = 1'b0;
    if (rn_hit1) begin
      rn_fwd = 2'd1;
      rn_val = s1_data;
    end else if (rn_hit2) begin
`ifdef FWD_WB_EN
      rn_fwd = 2'd2;
      rn_val = s2_data;
`else
      rn_raw = 1'b1;
`endif
    end
  end

  always_comb begin
    rm_fwd = 2'd0;
    rm_val = rm_rf;
    rm_raw = 1'b0;
    if (rm_hit1) begin
      rm_fwd = 2'd1;
      rm_val = s1_data;
    end else if (rm_hit2) begin
`ifdef FWD_WB_EN
      rm_fwd = 2'd2;
      rm_val = s2_data;
`else
      rm_raw = 1'b1;
`endif
    end
  end

`ifdef FWD_WB_EN
  assign raw_stall = 1'b0;
  logic unused_raw;
  assign unused_raw = rn_raw | rm_raw;
`else
  assign raw_stall = rn_raw | rm_raw;
`endif

  // S2 is written only on the cycle it advances; a reset in that cycle drops the write.
  assign wb_en   = s2_valid && s2_wr && !stall && !rst;
  assign wb_rd   = s2_rd;
  assign wb_data = s2_data;

endmodule

// File: tb/tb_fwd_unit.sv
// Scoreboard bench for fwd_unit: a queue-based model of in-flight results predicts each cycle's
// operand resolution and the ordered stream of register-file writes.
module tb_fwd_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [3:0]  in_opcode, in_rd, rn, rm;
  logic [31:0] in_result, rn_rf, rm_rf;
  logic [31:0] rn_val, rm_val, wb_data;
  logic [1:0]  rn_fwd, rm_fwd;
  logic        raw_stall, wb_en;
  logic [3:0]  wb_rd;

  always #5 clk = ~clk;

  fwd_unit #(.DATAW(32), .REGAW(4), .ALUAW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_result(in_result),
    .rn(rn), .rm(rm), .rn_rf(rn_rf), .rm_rf(rm_rf),
    .rn_val(rn_val), .rm_val(rm_val), .rn_fwd(rn_fwd), .rm_fwd(rm_fwd),
    .raw_stall(raw_stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [1:0]  fn, fm;
    logic [31:0] vn, vm;
    logic        raw, wen;
  } exp_t;

  ent_t hist[$];   // in-flight results, youngest first
  exp_t cq[$];
  ent_t wq[$];
  int checks = 0;
  int failures = 0;

  localparam logic [3:0] ADD = 4'h4;
  localparam logic [3:0] CMP = 4'hA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit writes(input bit v, input logic [3:0] op, input logic [3:0] rd);
    return v && !(op inside {4'h8, 4'h9, 4'hA, 4'hB}) && (rd != 4'hF);
  endfunction

  function automatic void resolve(input logic [3:0] src, input logic [31:0] rf,
                                  output logic [1:0] sel, output logic [31:0] val, output logic raw);
    bit found = 0;
    sel = 2'd0;
    raw = 1'b0;
    if (src != 4'hF) begin
      for (int i = 0; i < 2; i++) begin
        if (!found && hist[i].wr && hist[i].rd == src) begin
          sel = 2'(i + 1);
          found = 1;
        end
      end
    end
`ifndef FWD_WB_EN
    if (sel == 2'd2) begin
      sel = 2'd0;
      raw = 1'b1;
    end
`endif
    val = (sel == 2'd1) ? hist[0].data : (sel == 2'd2) ? hist[1].data : rf;
  endfunction

  task automatic step(input bit r, input bit s, input bit f, input bit v, input logic [3:0] op,
                      input logic [3:0] rd, input logic [31:0] res, input logic [3:0] a,
                      input logic [3:0] b);
    exp_t e;
    ent_t blank, nw;
    logic rawn, rawm;
    rst = r; stall = s; flush = f; in_valid = v;
    in_opcode = op; in_rd = rd; in_result = res; rn = a; rm = b;
    rn_rf = $urandom; rm_rf = $urandom;
    resolve(a, rn_rf, e.fn, e.vn, rawn);
    resolve(b, rm_rf, e.fm, e.vm, rawm);
    e.raw = rawn | rawm;
    e.wen = hist[1].wr && !s && !r;
    if (e.wen) wq.push_back(hist[1]);
    cq.push_back(e);
    @(posedge clk);
    blank = '{wr: 0, rd: 4'h0, data: 32'h0};
    nw = '{wr: writes(v, op, rd), rd: rd, data: res};
    if (r) begin
      hist = '{blank, blank};
    end else if (f && !s) begin
      hist.push_front(blank);
      void'(hist.pop_back());
    end else if (f) begin
      hist[0] = blank;
    end else if (!s) begin
      hist.push_front(nw);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] a, input logic [3:0] b);
    step(0, 0, 0, 0, 4'h0, 4'h0, 32'h0, a, b);
  endtask

  function automatic logic [3:0] pick_reg();
    int k = $urandom_range(0, 7);
    if (k == 7) return 4'hF;
    if (k == 6) return 4'($urandom_range(0, 15));
    return 4'(k + 1);
  endfunction

  exp_t mon_e;
  ent_t mon_w;
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      mon_e = cq.pop_front();
      chk("rn_fwd", 32'(rn_fwd), 32'(mon_e.fn));
      chk("rm_fwd", 32'(rm_fwd), 32'(mon_e.fm));
      chk("rn_val", rn_val, mon_e.vn);
      chk("rm_val", rm_val, mon_e.vm);
      chk("raw_stall", 32'(raw_stall), 32'(mon_e.raw));
      chk("wb_en", 32'(wb_en), 32'(mon_e.wen));
    end
    if (wb_en === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual rd=%0h data=%0h required no write", wb_rd, wb_data);
      end else begin
        mon_w = wq.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(mon_w.rd));
        chk("wb_data", wb_data, mon_w.data);
      end
    end
  end

  initial begin
    rst = 1; stall = 1; flush = 0; in_valid = 0; in_opcode = 0; in_rd = 0;
    in_result = 0; rn = 0; rm = 0; rn_rf = 0; rm_rf = 0;
    repeat (2) @(posedge clk);
    #1;
    hist = '{'{wr: 0, rd: 4'h0, data: 32'h0}, '{wr: 0, rd: 4'h0, data: 32'h0}};

    // idle after reset: everything passes through from the RF
    idle(4'h3, 4'h5);
    idle(4'hF, 4'h0);
    // back-to-back dependency
    step(0, 0, 0, 1, ADD, 4'h3, 32'h11, 4'h0, 4'h0);
    idle(4'h3, 4'h1);
    idle(4'h1, 4'h3);
    idle(4'h0, 4'h0);
    // two-deep dependency, S1 wins
    step(0, 0, 0, 1, ADD, 4'h3, 32'h11, 4'h0, 4'h0);
    step(0, 0, 0, 1, ADD, 4'h3, 32'h22, 4'h3, 4'h0);
    idle(4'h3, 4'h3);
    idle(4'h3, 4'h2);
    idle(4'h0, 4'h0);
    // flag-only opcode and an R15 write never forward or write back
    step(0, 0, 0, 1, CMP, 4'h3, 32'h33, 4'h0, 4'h0);
    step(0, 0, 0, 1, ADD, 4'hF, 32'h44, 4'h3, 4'h3);
    idle(4'h3, 4'hF);
    idle(4'hF, 4'h3);
    // stall with S2 holding r5
    step(0, 0, 0, 1, ADD, 4'h5, 32'h7, 4'h0, 4'h0);
    idle(4'h5, 4'h0);
    step(0, 1, 0, 1, ADD, 4'h6, 32'h8, 4'h5, 4'h5);
    step(0, 1, 0, 1, ADD, 4'h6, 32'h8, 4'h5, 4'h6);
    step(0, 1, 0, 0, ADD, 4'h6, 32'h8, 4'h5, 4'h0);
    idle(4'h5, 4'h5);
    idle(4'h0, 4'h0);
    // flush with a valid instruction, alone and combined with stall
    step(0, 0, 1, 1, ADD, 4'h6, 32'h99, 4'h0, 4'h0);
    idle(4'h6, 4'h6);
    step(0, 0, 0, 1, ADD, 4'h7, 32'h77, 4'h0, 4'h0);
    step(0, 0, 0, 1, ADD, 4'h8, 32'h88, 4'h7, 4'h0);
    step(0, 1, 1, 1, ADD, 4'h9, 32'h99, 4'h7, 4'h8);
    idle(4'h7, 4'h8);
    idle(4'h9, 4'h7);
    idle(4'h0, 4'h0);
    // reset mid-stream with both slots valid
    step(0, 0, 0, 1, ADD, 4'h1, 32'hA1, 4'h0, 4'h0);
    step(0, 0, 0, 1, ADD, 4'h2, 32'hA2, 4'h1, 4'h0);
    step(1, 1, 0, 1, ADD, 4'h4, 32'hA4, 4'h1, 4'h2);
    idle(4'h1, 4'h2);
    idle(4'h2, 4'h4);

    for (int n = 0; n < 3000; n++) begin
      bit r, s, f, v;
      logic [3:0] op;
      r = ($urandom_range(0, 99) < 1);
      s = r ? 1'b1 : ($urandom_range(0, 99) < 20);
      f = ($urandom_range(0, 99) < 10);
      v = ($urandom_range(0, 99) < 75);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 11)) : 4'($urandom_range(0, 15));
      step(r, s, f, v, op, pick_reg(), $urandom, pick_reg(), pick_reg());
    end

    idle(4'h0, 4'h0);
    idle(4'h0, 4'h0);
    @(negedge clk);
    #1;
    chk("expect_queue_drained", 32'(cq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
